// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller and its
// address checker.
package ifetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] NOP            = 32'h0000_0013;
  localparam logic [3:0]  CAUSE_MISALIGN = 4'd0;
  localparam logic [3:0]  CAUSE_ACCESS   = 4'd1;

endpackage

// File: rtl/ifetch_addr_chk.sv
// Combinational fetch-address check: misalignment first, then out-of-range
// access against a ROM of 2^ROM_DEPTH 32-bit words.
module ifetch_addr_chk
  import ifetch_pkg::*;
#(
  parameter int ROM_DEPTH = 10
) (
  input  logic [31:0] i_target,
  output logic        o_fault,
  output logic [3:0]  o_cause
);

  // One extra bit so the limit stays representable for large ROM_DEPTH.
  localparam logic [32:0] LIMIT = 33'd4 << ROM_DEPTH;

  logic w_misalign;
  logic w_range;

  always_comb begin
    w_misalign = (i_target[1:0] != 2'b00);
    w_range    = ({1'b0, i_target} >= LIMIT);
    o_fault    = w_misalign | w_range;
    o_cause    = w_misalign ? CAUSE_MISALIGN : CAUSE_ACCESS;
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives a 1-cycle-latency ROM and
// presents one packet per cycle to IF/ID with stall, redirect and trap support.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_DEPTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  output logic        irom_en,
  output logic [31:0] irom_adr,
  input  logic [31:0] irom_inst,
  input  logic        id_ready,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        trap_en,
  input  logic [31:0] trap_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_fault,
  output logic [3:0]  if_fault_cause
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_adr;
  logic        r_resp_valid;
  logic        r_resp_fault;
  logic [3:0]  r_cause;

  logic        w_redir;
  logic [31:0] w_target;
  logic        w_issue;
  logic        w_fault;
  logic [3:0]  w_cause;

  ifetch_addr_chk #(
    .ROM_DEPTH (ROM_DEPTH)
  ) u_addr_chk (
    .i_target (w_target),
    .o_fault  (w_fault),
    .o_cause  (w_cause)
  );

  // Redirects issue in any state, so they always overwrite a held packet.
  always_comb begin
    w_redir     = trap_en | redirect_en;
    w_target    = trap_en ? trap_pc : (redirect_en ? redirect_pc : r_pc);
    w_issue     = ((r_state == RUN) | w_redir) &
                  (w_redir | ~r_resp_valid | id_ready);
    w_state_nxt = r_state;
    if (r_state == BOOT) begin
      w_state_nxt = RUN;
    end
    if (w_issue) begin
      w_state_nxt = w_fault ? HALT : RUN;
    end
    irom_en  = w_issue & ~w_fault;
    irom_adr = irom_en ? w_target : r_adr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_req_pc     <= RESET_PC;
      r_adr        <= RESET_PC;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_cause      <= CAUSE_MISALIGN;
    end else begin
      r_adr <= irom_adr;
      if (w_issue) begin
        r_req_pc     <= w_target;
        r_resp_valid <= 1'b1;
        r_resp_fault <= w_fault;
        r_cause      <= w_fault ? w_cause : CAUSE_MISALIGN;
        if (!w_fault) begin
          r_pc <= w_target + 32'd4;
        end
      end else if (id_ready && r_resp_valid) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    if_valid       = r_resp_valid;
    if_pc          = r_req_pc;
    if_inst        = r_resp_fault ? NOP : irom_inst;
    if_fault       = r_resp_fault;
    if_fault_cause = r_cause;
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a behavioural 1-cycle-latency ROM whose
// word i holds 32'hA000_0000 | i.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irom_en;
  logic [31:0] irom_adr;
  logic [31:0] irom_inst = 32'h0;
  logic        id_ready = 1'b1;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        trap_en = 1'b0;
  logic [31:0] trap_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_fault;
  logic [3:0]  if_fault_cause;

  logic [31:0] mem [0:1023];
  int total = 0;
  int bad   = 0;

  ifetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .ROM_DEPTH (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .irom_en        (irom_en),
    .irom_adr       (irom_adr),
    .irom_inst      (irom_inst),
    .id_ready       (id_ready),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .trap_en        (trap_en),
    .trap_pc        (trap_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_fault       (if_fault),
    .if_fault_cause (if_fault_cause)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (irom_en) irom_inst <= mem[irom_adr[11:2]];
  end

  function automatic logic [31:0] rw(input logic [31:0] byte_adr);
    return 32'hA000_0000 | (byte_adr >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pkt(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_inst"}, if_inst, inst);
    chk({tag, "_fault"}, {31'b0, if_fault}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;

    // Reset state
    tick();
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_en", {31'b0, irom_en}, 32'd0);
    chk("rst_adr", irom_adr, 32'h0);
    chk("rst_fault", {31'b0, if_fault}, 32'd0);
    chk("rst_cause", {28'b0, if_fault_cause}, 32'd0);

    // Release: BOOT for one cycle, first issue next, first packet after that
    rst = 1'b0;
    #1;
    chk("boot_en", {31'b0, irom_en}, 32'd0);
    tick();
    chk("run_en", {31'b0, irom_en}, 32'd1);
    chk("run_adr", irom_adr, 32'h0);
    chk("run_valid", {31'b0, if_valid}, 32'd0);
    tick();
    pkt("p0", 32'h0, rw(32'h0));
    tick();
    pkt("p4", 32'h4, rw(32'h4));
    tick();
    pkt("p8", 32'h8, rw(32'h8));

    // Stall at pc 8 for three cycles
    id_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_en", {31'b0, irom_en}, 32'd0);
      pkt("stall", 32'h8, rw(32'h8));
      if (k < 2) tick();
    end
    tick();
    id_ready = 1'b1;
    #1;
    pkt("stall_rel", 32'h8, rw(32'h8));
    chk("stall_rel_adr", irom_adr, 32'hC);
    tick();
    pkt("pC", 32'hC, rw(32'hC));
    tick();
    pkt("p10", 32'h10, rw(32'h10));

    // Redirect while the 0x10 packet is stalled
    id_ready = 1'b0;
    tick();
    pkt("p10_held", 32'h10, rw(32'h10));
    redirect_en = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("redir_en", {31'b0, irom_en}, 32'd1);
    chk("redir_adr", irom_adr, 32'h40);
    tick();
    redirect_en = 1'b0;
    id_ready = 1'b1;
    pkt("p40", 32'h40, rw(32'h40));
    tick();
    pkt("p44", 32'h44, rw(32'h44));

    // Trap beats redirect in the same cycle
    trap_en = 1'b1;
    trap_pc = 32'h80;
    redirect_en = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("prio_adr", irom_adr, 32'h80);
    tick();
    trap_en = 1'b0;
    redirect_en = 1'b0;
    pkt("p80", 32'h80, rw(32'h80));

    // Misaligned redirect target
    redirect_en = 1'b1;
    redirect_pc = 32'h1002;
    #1;
    chk("mis_en", {31'b0, irom_en}, 32'd0);
    tick();
    redirect_en = 1'b0;
    #1;
    chk("mis_valid", {31'b0, if_valid}, 32'd1);
    chk("mis_fault", {31'b0, if_fault}, 32'd1);
    chk("mis_cause", {28'b0, if_fault_cause}, 32'd0);
    chk("mis_inst", if_inst, 32'h0000_0013);
    chk("mis_pc", if_pc, 32'h1002);
    chk("halt_en", {31'b0, irom_en}, 32'd0);
    tick();
    chk("halt_valid", {31'b0, if_valid}, 32'd0);
    chk("halt_en2", {31'b0, irom_en}, 32'd0);

    // Out-of-range redirect target while halted
    redirect_en = 1'b1;
    redirect_pc = 32'h1000;
    #1;
    chk("acc_en", {31'b0, irom_en}, 32'd0);
    tick();
    redirect_en = 1'b0;
    #1;
    chk("acc_fault", {31'b0, if_fault}, 32'd1);
    chk("acc_cause", {28'b0, if_fault_cause}, 32'd1);
    chk("acc_inst", if_inst, 32'h0000_0013);
    chk("acc_pc", if_pc, 32'h1000);
    tick();
    chk("halt2_en", {31'b0, irom_en}, 32'd0);
    tick();
    chk("halt3_en", {31'b0, irom_en}, 32'd0);

    // Trap resumes fetch
    trap_en = 1'b1;
    trap_pc = 32'h20;
    #1;
    chk("trap_en", {31'b0, irom_en}, 32'd1);
    chk("trap_adr", irom_adr, 32'h20);
    tick();
    trap_en = 1'b0;
    pkt("p20", 32'h20, rw(32'h20));
    tick();
    pkt("p24", 32'h24, rw(32'h24));

    // Asynchronous reset mid-stream
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, if_valid}, 32'd0);
    chk("arst_adr", irom_adr, 32'h0);
    chk("arst_en", {31'b0, irom_en}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("reboot_en", {31'b0, irom_en}, 32'd0);
    tick();
    chk("refetch_en", {31'b0, irom_en}, 32'd1);
    chk("refetch_adr", irom_adr, 32'h0);
    tick();
    pkt("rp0", 32'h0, rw(32'h0));
    tick();
    pkt("rp4", 32'h4, rw(32'h4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
